wb_spi_tgt: RTL

//  SPI target (slave) with Wishbone data port for FazyRV-ExoTiny. An external SPI

---
 rtl/wb_spi_tgt.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/wb_spi_tgt.sv
// SPI target with a Wishbone data port. All SPI inputs are resynchronised into clk_i.
// The controller drives CS/SCK/SDI. The CPU loads one TX word per frame and reads the last RX word.
module wb_spi_tgt #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        wb_spi_cyc_i,
  input  logic        wb_spi_stb_i,
  input  logic        wb_spi_we_i,
  output logic        wb_spi_ack_o,
  input  logic [31:0] wb_spi_dat_i,
  output logic [31:0] wb_spi_dat_o,
  input  logic [1:0]  size_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  output logic        rdy_o,
  output logic        valid_o,
  output logic        ovr_o,
  input  logic        spi_cs_i,
  input  logic        spi_sck_i,
  input  logic        spi_sdi_i,
  output logic        spi_sdo_o,
  output logic        spi_sdo_oe_o
);

  typedef enum logic [1:0] {StIdle, StAct, StDone} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sdi_sync;
  logic                   cs_q, sck_q;
  logic [31:0]            tx_q;
  logic [30:0]            rx_shift_q;
  logic [31:0]            rx_q;
  logic [5:0]             cnt_q;
  logic                   cpol_q, cpha_q, first_q;
  logic [1:0]             size_q;
  logic                   valid_q, ovr_q;

  logic        cs_s, sck_s, sdi_s;
  logic        cs_fall, cs_rise, lead, trail;
  logic        rx_sample, tx_shift, last;
  logic        wr, rd;
  logic [5:0]  frame_bits;
  logic [31:0] rx_next;

  always_comb begin
    cs_s       = cs_sync[SYNC_STAGES-1];
    sck_s      = sck_sync[SYNC_STAGES-1];
    sdi_s      = sdi_sync[SYNC_STAGES-1];
    cs_fall    = cs_q & ~cs_s;
    cs_rise    = ~cs_q & cs_s;
    lead       = (sck_s != sck_q) && (sck_q == cpol_q);
    trail      = (sck_s != sck_q) && (sck_s == cpol_q);
    // cpha=1 holds the first bit through the first leading edge
    rx_sample  = cpha_q ? trail : lead;
    tx_shift   = cpha_q ? (lead & ~first_q) : trail;
    frame_bits = {1'b0, size_q, 3'b000} + 6'd8;
    last       = (cnt_q + 6'd1) == frame_bits;
    rx_next    = {rx_shift_q, sdi_s};
    wr         = wb_spi_cyc_i & wb_spi_stb_i & wb_spi_we_i;
    rd         = wb_spi_cyc_i & wb_spi_stb_i & ~wb_spi_we_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      cs_sync    <= '1;
      sck_sync   <= {SYNC_STAGES{cpol_i}};
      sdi_sync   <= '0;
      cs_q       <= 1'b1;
      sck_q      <= cpol_i;
      state_q    <= StIdle;
      tx_q       <= '0;
      rx_shift_q <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      cpol_q     <= cpol_i;
      cpha_q     <= 1'b0;
      size_q     <= '0;
      first_q    <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
      cs_q     <= cs_s;
      sck_q    <= sck_s;
      if (wr) ovr_q <= 1'b0;
      if (rd) valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (wr) tx_q <= wb_spi_dat_i;
          if (cs_fall) begin
            state_q    <= StAct;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            cpol_q     <= cpol_i;
            cpha_q     <= cpha_i;
            size_q     <= size_i;
            first_q    <= 1'b1;
          end
        end
        StAct: begin
          if (cs_rise) begin
            state_q <= StIdle;
            tx_q    <= '0;
          end else begin
            if (lead) first_q <= 1'b0;
            if (tx_shift) tx_q <= {tx_q[30:0], 1'b0};
            if (rx_sample) begin
              rx_shift_q <= rx_next[30:0];
              cnt_q      <= cnt_q + 6'd1;
              if (last) begin
                rx_q    <= rx_next;
                valid_q <= 1'b1;
                // a read in the same cycle consumes the old word, so no overrun
                if (valid_q && !rd) ovr_q <= 1'b1;
                state_q <= StDone;
              end
            end
          end
        end
        StDone: begin
          if (cs_rise) begin
            state_q <= StIdle;
            tx_q    <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb_spi_ack_o = wb_spi_cyc_i & wb_spi_stb_i;
  assign wb_spi_dat_o = rx_q;
  assign rdy_o        = (state_q == StIdle);
  assign valid_o      = valid_q;
  assign ovr_o        = ovr_q;
  assign spi_sdo_o    = (state_q == StAct) & tx_q[31];
  assign spi_sdo_oe_o = ~cs_q;

endmodule
